// File: rtl/iob_fifo_wr_ctrl.sv
// iob_fifo_wr_ctrl: write-side pointer, Gray export and full/level flags for a dual-clock FIFO
module iob_fifo_wr_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 2**ADDR_W-1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [ADDR_W:0]   r_gray_ptr_i,
  output logic              mem_w_en_o,
  output logic [ADDR_W-1:0] mem_w_addr_o,
  output logic [ADDR_W:0]   w_gray_ptr_o,
  output logic              w_full_o,
  output logic              w_afull_o,
  output logic [ADDR_W:0]   w_level_o,
  output logic              w_ovf_o
);
  localparam int PW = ADDR_W+1;
  logic [PW-1:0] wbin_q, wbin_d, gray_q, gray_d, level_q, level_d, rbin;
  logic          full_q, full_d, afull_q, afull_d, ovf_q, ovf_d, accept;
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign rbin[i] = ^r_gray_ptr_i[PW-1:i];
  end
  assign accept       = cke_i & w_en_i & ~full_q & ~rst_i;
  assign mem_w_en_o   = accept;
  assign mem_w_addr_o = wbin_q[ADDR_W-1:0];
  assign w_gray_ptr_o = gray_q;
  assign w_full_o     = full_q;
  assign w_afull_o    = afull_q;
  assign w_level_o    = level_q;
  assign w_ovf_o      = ovf_q;
  // next pointer/level/flags; level is taken against the post-accept pointer so flags track the write
  always_comb begin
    wbin_d  = rst_i ? '0 : wbin_q + PW'(accept);
    gray_d  = wbin_d ^ (wbin_d >> 1);
    level_d = rst_i ? '0 : wbin_d - rbin;
    full_d  = ~rst_i & (level_d == PW'(2**ADDR_W));
    afull_d = ~rst_i & (level_d >= PW'(AFULL_LVL));
    ovf_d   = ~rst_i & (ovf_q | (w_en_i & full_q));
  end
  // state registers, frozen while the clock enable is low
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wbin_q  <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (cke_i) begin
      wbin_q  <= wbin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_iob_fifo_wr_ctrl.sv
// tb_iob_fifo_wr_ctrl: directed and random stimulus checked against a count-based FIFO model
module tb_iob_fifo_wr_ctrl;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFL = 3;
  logic          clk_i = 0, cke_i = 0, arst_i = 1, rst_i = 0, w_en_i = 0;
  logic [AW:0]   r_gray_ptr_i = '0;
  logic          mem_w_en_o, w_full_o, w_afull_o, w_ovf_o;
  logic [AW-1:0] mem_w_addr_o;
  logic [AW:0]   w_gray_ptr_o, w_level_o;
  int n_vec = 0, n_err = 0;
  int wcnt = 0, rcnt = 0, lvl = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  iob_fifo_wr_ctrl #(.ADDR_W(AW), .AFULL_LVL(AFL)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .rst_i(rst_i), .w_en_i(w_en_i),
    .r_gray_ptr_i(r_gray_ptr_i), .mem_w_en_o(mem_w_en_o), .mem_w_addr_o(mem_w_addr_o),
    .w_gray_ptr_o(w_gray_ptr_o), .w_full_o(w_full_o), .w_afull_o(w_afull_o),
    .w_level_o(w_level_o), .w_ovf_o(w_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int gray(input int n);
    int b;
    b = n % (2*DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (wcnt=%0d rcnt=%0d t=%0t)", tag, got, exp, wcnt, rcnt, $time);
    end
  endtask

  task automatic chk_regs;
    chk("gray", w_gray_ptr_o, gray(wcnt));
    chk("level", w_level_o, lvl);
    chk("full", w_full_o, m_full);
    chk("afull", w_afull_o, m_afull);
    chk("ovf", w_ovf_o, m_ovf);
  endtask

  task automatic step(input bit cke, input bit wen, input bit rst, input int radv);
    bit acc;
    rcnt = rst ? 0 : ((rcnt + radv > wcnt) ? wcnt : rcnt + radv);
    cke_i = cke;
    w_en_i = wen;
    rst_i = rst;
    r_gray_ptr_i = (AW+1)'(gray(rcnt));
    acc = cke & wen & ~m_full & ~rst;
    #1;
    chk("mem_w_en", mem_w_en_o, acc);
    chk("mem_w_addr", mem_w_addr_o, wcnt % DEPTH);
    @(posedge clk_i);
    #1;
    if (cke) begin
      if (rst) begin
        wcnt = 0;
        m_ovf = 0;
      end else begin
        if (wen && m_full) m_ovf = 1;
        if (acc) wcnt++;
      end
      lvl = wcnt - rcnt;
      m_full = (lvl == DEPTH);
      m_afull = (lvl >= AFL);
    end
    chk_regs();
  endtask

  initial begin
    #12;
    chk("arst_gray", w_gray_ptr_o, 0);
    chk("arst_full", w_full_o, 0);
    arst_i = 0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit c, r;
      c = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 99) < 2);
      step(c | r, $urandom_range(0, 9) < 6, r, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0);
      if (i == 1500) begin
        w_en_i = 0;
        r_gray_ptr_i = '0;
        arst_i = 1;
        #1;
        chk("arst_mem_w_en", mem_w_en_o, 0);
        chk("arst_addr", mem_w_addr_o, 0);
        wcnt = 0;
        rcnt = 0;
        lvl = 0;
        m_full = 0;
        m_afull = 0;
        m_ovf = 0;
        chk_regs();
        #2;
        arst_i = 0;
        @(posedge clk_i);
        #1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
